// File: rtl/hack_pkg.sv
// hack_pkg: shared types and constants for the Hack CPU program-counter stage.
//   WORD_W     - Hack machine word width in bits.
//   JMP_*/J*   - C-instruction jump field encodings, {j1,j2,j3} = {lt,eq,gt}.
//   pc_state_t - PC stage control state (RUN or HALTED).
package hack_pkg;

  localparam int WORD_W = 16;

  localparam logic [2:0] JMP_NULL = 3'b000;
  localparam logic [2:0] JGT      = 3'b001;
  localparam logic [2:0] JEQ      = 3'b010;
  localparam logic [2:0] JGE      = 3'b011;
  localparam logic [2:0] JLT      = 3'b100;
  localparam logic [2:0] JNE      = 3'b101;
  localparam logic [2:0] JLE      = 3'b110;
  localparam logic [2:0] JMP      = 3'b111;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_t;

endpackage

// File: rtl/hack_pc_jump_jump_cond.sv
// jump_cond: combinational Hack jump-condition decoder.
//   zr        - ALU output is zero
//   ng        - ALU output is negative
//   jump_bits - {j1,j2,j3} = {lt,eq,gt} select
//   is_c_inst - current instruction is a C-instruction
//   cond      - jump is taken
// zr and ng both set is treated as "equal": lt and gt are masked by zr.
module jump_cond (
  input  logic       zr,
  input  logic       ng,
  input  logic [2:0] jump_bits,
  input  logic       is_c_inst,
  output logic       cond
);

  logic lt;
  logic eq;
  logic gt;

  // Derive the three relations from the flags and select by the jump field.
  always_comb begin
    lt   = ng & ~zr;
    eq   = zr;
    gt   = ~ng & ~zr;
    cond = is_c_inst & ((jump_bits[2] & lt) |
                        (jump_bits[1] & eq) |
                        (jump_bits[0] & gt));
  end

endmodule

// File: rtl/hack_pc_jump.sv
// hack_pc_jump: Hack CPU program-counter stage.
// Decides jumps from the ALU flags and the C-instruction jump field, holds the
// PC register that addresses instruction ROM, and counts advances.
// Optional feature macro: HACK_PC_HALT_DETECT_EN
//   defined   - the "@X; 0;JMP at X" idiom freezes the PC in a HALTED state
//               that only reset leaves.
//   undefined - no HALTED state; halted is tied low and a self-jump simply
//               reloads the same address every advance.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   en         - advance enable (0 = stall)
//   is_c_inst  - instruction is a C-instruction
//   jump_bits  - {j1,j2,j3} jump select
//   zr, ng     - ALU zero / negative flags
//   a_reg      - jump target
//   pc         - current instruction address (registered)
//   jump_taken - previous advance was a taken jump (registered)
//   halted     - block is HALTED (registered)
//   step_count - advances since reset (registered, wraps)
module hack_pc_jump
  import hack_pkg::*;
#(
  parameter int               WIDTH        = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             is_c_inst,
  input  logic [2:0]       jump_bits,
  input  logic             zr,
  input  logic             ng,
  input  logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] pc,
  output logic             jump_taken,
  output logic             halted,
  output logic [31:0]      step_count
);

  localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  pc_state_t        state_q;
  pc_state_t        state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             jump_taken_q;
  logic             jump_taken_d;
  logic [31:0]      step_count_q;
  logic [31:0]      step_count_d;
  logic             cond;

  jump_cond u_jump_cond (
    .zr        (zr),
    .ng        (ng),
    .jump_bits (jump_bits),
    .is_c_inst (is_c_inst),
    .cond      (cond)
  );

`ifdef HACK_PC_HALT_DETECT_EN
  logic halted_q;
  logic halted_d;
  logic halt_hit;

  // Halt idiom: an unconditional jump whose target is the current address.
  always_comb begin
    halt_hit = is_c_inst & (jump_bits == JMP) & (a_reg == pc_q);
  end
`endif

  // Next-state and next-output logic for the PC stage.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    jump_taken_d = 1'b0;
    step_count_d = step_count_q;
`ifdef HACK_PC_HALT_DETECT_EN
    halted_d     = halted_q;
`endif
    case (state_q)
      RUN: begin
        if (en) begin
          step_count_d = step_count_q + 32'd1;
          if (cond) begin
            pc_d         = a_reg;
            jump_taken_d = 1'b1;
`ifdef HACK_PC_HALT_DETECT_EN
            if (halt_hit) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end else begin
              state_d  = RUN;
            end
`endif
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      HALTED: begin
        // Frozen until reset; only jump_taken drops back to 0.
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      jump_taken_q <= 1'b0;
      step_count_q <= 32'd0;
`ifdef HACK_PC_HALT_DETECT_EN
      halted_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      jump_taken_q <= jump_taken_d;
      step_count_q <= step_count_d;
`ifdef HACK_PC_HALT_DETECT_EN
      halted_q     <= halted_d;
`endif
    end
  end

  assign pc         = pc_q;
  assign jump_taken = jump_taken_q;
  assign step_count = step_count_q;
`ifdef HACK_PC_HALT_DETECT_EN
  assign halted     = halted_q;
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_hack_pc_jump.sv
// Scoreboard bench for hack_pc_jump: stimulus pushes the expected post-edge
// outputs from a behavioural model; a monitor pops and compares after every edge.
module tb_hack_pc_jump;
  import hack_pkg::*;

  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        is_c_inst = 1'b0;
  logic [2:0]  jump_bits = 3'b000;
  logic        zr = 1'b0;
  logic        ng = 1'b0;
  logic [15:0] a_reg = 16'h0000;
  logic [15:0] pc;
  logic        jump_taken;
  logic        halted;
  logic [31:0] step_count;

  always #5 clk = ~clk;

  hack_pc_jump #(.WIDTH(16), .RESET_VECTOR(RV)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .is_c_inst  (is_c_inst),
    .jump_bits  (jump_bits),
    .zr         (zr),
    .ng         (ng),
    .a_reg      (a_reg),
    .pc         (pc),
    .jump_taken (jump_taken),
    .halted     (halted),
    .step_count (step_count)
  );

  typedef struct {
    logic [15:0] pc;
    logic        jt;
    logic        h;
    logic [31:0] sc;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: what the PC stage should hold after the next edge.
  logic [15:0] m_pc = 16'h0000;
  logic [31:0] m_sc = 32'd0;
  bit          m_h  = 1'b0;

  // Jump decision by mnemonic, from the ALU value's relation to zero.
  function automatic bit ref_cond(bit c, logic [2:0] jb, bit z, bit n);
    bit is_eq, is_lt, is_gt, r;
    is_eq = z;
    is_lt = n && !z;
    is_gt = !n && !z;
    case (jb)
      JMP_NULL: r = 1'b0;
      JGT:      r = is_gt;
      JEQ:      r = is_eq;
      JGE:      r = is_gt || is_eq;
      JLT:      r = is_lt;
      JNE:      r = !is_eq;
      JLE:      r = is_lt || is_eq;
      default:  r = 1'b1;
    endcase
    return c && r;
  endfunction

  task automatic drive(bit rst, bit e, bit c, logic [2:0] jb, bit z, bit n,
                       logic [15:0] a, string tag);
    exp_t x;
    bit   jt;
    @(negedge clk);
    reset = rst; en = e; is_c_inst = c; jump_bits = jb; zr = z; ng = n; a_reg = a;
    jt = 1'b0;
    if (rst) begin
      m_pc = RV; m_sc = 32'd0; m_h = 1'b0;
    end else if (m_h) begin
      jt = 1'b0;
    end else if (e) begin
      if (ref_cond(c, jb, z, n)) begin
`ifdef HACK_PC_HALT_DETECT_EN
        if (c && jb == JMP && a == m_pc) m_h = 1'b1;
`endif
        m_pc = a;
        jt   = 1'b1;
      end else begin
        m_pc = m_pc + 16'd1;
      end
      m_sc = m_sc + 32'd1;
    end
    x.pc = m_pc; x.jt = jt; x.h = m_h; x.sc = m_sc; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents new outputs after every rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk({x.tag, ".pc"},         {16'h0, pc},          {16'h0, x.pc});
        chk({x.tag, ".jump_taken"}, {31'h0, jump_taken},  {31'h0, x.jt});
        chk({x.tag, ".halted"},     {31'h0, halted},      {31'h0, x.h});
        chk({x.tag, ".step_count"}, step_count,           x.sc);
      end
    end
  end

  initial begin
    bit        z, n, r, e, c;
    logic [15:0] a;

    drive(1, 0, 0, 3'b000, 0, 0, 16'h0000, "reset");
    drive(1, 1, 1, JMP, 0, 0, 16'h1234, "reset_prio");
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 3'b000, 0, 0, 16'h0000, "count");

    // Every jump field against each flag combination, C and A instructions.
    for (int ci = 1; ci >= 0; ci--) begin
      for (int jb = 0; jb < 8; jb++) begin
        for (int f = 0; f < 4; f++) begin
          z = (f == 0) || (f == 3);
          n = (f == 1) || (f == 3);
          drive(0, 1, ci[0], jb[2:0], z, n, 16'h0100, "sweep");
          drive(0, 1, 0, 3'b000, 0, 0, 16'h0100, "sep");
        end
      end
    end

    // PC wrap at the top of the address space.
    drive(0, 1, 1, JMP, 0, 0, 16'hFFFF, "to_ffff");
    drive(0, 1, 0, 3'b000, 0, 0, 16'h0000, "wrap");
    drive(0, 1, 0, 3'b000, 0, 0, 16'h0000, "after_wrap");

    // Stall with a satisfied jump condition.
    for (int i = 0; i < 3; i++) drive(0, 0, 1, JMP, 0, 0, 16'h0200, "stall");
    drive(0, 1, 1, JEQ, 1, 0, 16'h0200, "resume");

    // Halt idiom.
    drive(0, 1, 1, JMP, 0, 0, 16'h0010, "to_0010");
    drive(0, 1, 1, JGE, 1, 0, 16'h0010, "cond_self");
    drive(0, 1, 1, JMP, 0, 0, 16'h0010, "halt_entry");
    drive(0, 1, 1, JMP, 0, 0, 16'h0010, "self_again");
    drive(0, 1, 1, JMP, 0, 0, 16'h0020, "after_halt");
    drive(0, 0, 1, JMP, 0, 0, 16'h0020, "halt_stall");
    drive(0, 1, 0, 3'b000, 0, 0, 16'h0020, "halt_inc");
    drive(1, 1, 1, JMP, 0, 0, 16'h0020, "halt_reset");
    drive(0, 1, 0, 3'b000, 0, 0, 16'h0000, "post_reset");

    // Randomized traffic with frequent self-targets.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 3) != 0);
      c = $urandom_range(0, 1) == 1;
      z = $urandom_range(0, 1) == 1;
      n = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 3) == 0) ? m_pc : 16'($urandom);
      drive(r, e, c, 3'($urandom_range(0, 7)), z, n, a, "rand");
    end

    @(negedge clk);
    en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
